// File: rtl/alignment_traceback.sv
// alignment_traceback
// Walks the DP traceback-direction RAM from cell (len_b, len_c) back to (0,0)
// and writes the edit command arrays CommandsB/CommandsC back-to-front, so the
// valid path ends up in forward order at the top of each array.
// Optional build macro: TRACEBACK_MISMATCH_EN widens dir_rd_data to 3 bits and
// adds code 3'b100 (diagonal mismatch, DELETE on both sequences).
module alignment_traceback #(
  parameter int LEN = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(LEN+1)-1:0]     len_b,
  input  logic [$clog2(LEN+1)-1:0]     len_c,
  output logic                         dir_rd_en,
  output logic [$clog2(LEN+1)-1:0]     dir_rd_row,
  output logic [$clog2(LEN+1)-1:0]     dir_rd_col,
`ifdef TRACEBACK_MISMATCH_EN
  input  logic [2:0]                   dir_rd_data,
`else
  input  logic [1:0]                   dir_rd_data,
`endif
  output logic [0:3*LEN][0:2]          CommandsB,
  output logic [0:3*LEN][0:2]          CommandsC,
  output logic [$clog2(3*LEN+2)-1:0]   path_len,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int IW  = $clog2(LEN+1);
  localparam int WPW = $clog2(3*LEN+1);
  localparam int PLW = $clog2(3*LEN+2);

  localparam logic [WPW-1:0] WP_TOP = WPW'(3*LEN);
  localparam logic [IW:0]    LEN_L  = (IW+1)'(LEN);

`ifdef TRACEBACK_MISMATCH_EN
  localparam logic [2:0] CMD_DELETE = 3'b000;
`endif
  localparam logic [2:0] CMD_INSERT = 3'b001;
  localparam logic [2:0] CMD_KEEP   = 3'b010;
  localparam logic [2:0] CMD_NOP    = 3'b011;

  localparam logic [0:3*LEN][0:2] ALL_NOP = {(3*LEN+1){CMD_NOP}};

  typedef enum logic [1:0] {IDLE, STEP, EVAL, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  i;
  logic [IW-1:0]  j;
  logic [WPW-1:0] wp;

  logic           rd_step;
  logic [2:0]     dec_b;
  logic [2:0]     dec_c;
  logic           dec_di;
  logic           dec_dj;
  logic           dec_bad;

  logic           len_bad;

  assign len_bad = ({1'b0, len_b} > LEN_L) || ({1'b0, len_c} > LEN_L);

  // Issue a RAM read during STEP whenever the walk is strictly inside the grid
  always_comb begin
    rd_step    = (state == STEP) && (i != '0) && (j != '0);
    dir_rd_en  = rd_step;
    dir_rd_row = rd_step ? i : '0;
    dir_rd_col = rd_step ? j : '0;
  end

  // Decode the direction code returned by the RAM into commands and index moves
  always_comb begin
    dec_b   = CMD_KEEP;
    dec_c   = CMD_KEEP;
    dec_di  = 1'b0;
    dec_dj  = 1'b0;
    dec_bad = 1'b0;
    case (dir_rd_data)
`ifdef TRACEBACK_MISMATCH_EN
      3'b000: begin dec_di = 1'b1; dec_dj = 1'b1; end
      3'b001: begin dec_c = CMD_INSERT; dec_di = 1'b1; end
      3'b010: begin dec_b = CMD_INSERT; dec_dj = 1'b1; end
      3'b100: begin
        dec_b  = CMD_DELETE;
        dec_c  = CMD_DELETE;
        dec_di = 1'b1;
        dec_dj = 1'b1;
      end
`else
      2'b00: begin dec_di = 1'b1; dec_dj = 1'b1; end
      2'b01: begin dec_c = CMD_INSERT; dec_di = 1'b1; end
      2'b10: begin dec_b = CMD_INSERT; dec_dj = 1'b1; end
`endif
      default: dec_bad = 1'b1;
    endcase
  end

  // Traceback FSM: walks the path, fills the command arrays, reports completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      wp        <= WP_TOP;
      CommandsB <= ALL_NOP;
      CommandsC <= ALL_NOP;
      path_len  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i         <= len_b;
            j         <= len_c;
            wp        <= WP_TOP;
            CommandsB <= ALL_NOP;
            CommandsC <= ALL_NOP;
            path_len  <= '0;
            busy      <= 1'b1;
            if (len_bad) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= STEP;
            end
          end
        end
        STEP: begin
          if (i == '0 && j == '0) begin
            state <= DONE;
          end else if (i == '0) begin
            CommandsB[wp] <= CMD_INSERT;
            CommandsC[wp] <= CMD_KEEP;
            j             <= j - 1'b1;
            wp            <= wp - 1'b1;
          end else if (j == '0) begin
            CommandsB[wp] <= CMD_KEEP;
            CommandsC[wp] <= CMD_INSERT;
            i             <= i - 1'b1;
            wp            <= wp - 1'b1;
          end else begin
            state <= EVAL;
          end
        end
        EVAL: begin
          if (dec_bad) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            CommandsB[wp] <= dec_b;
            CommandsC[wp] <= dec_c;
            i             <= i - IW'(dec_di);
            j             <= j - IW'(dec_dj);
            wp            <= wp - 1'b1;
            state         <= STEP;
          end
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          path_len <= PLW'(WP_TOP - wp);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
